// File: rtl/key_conditioner.sv
// key_conditioner
//   Conditions the six raw time-setting buttons (hour/minute/second, up/down).
//   Each key is synchronised, debounced, turned into a one-cycle press pulse,
//   and auto-repeated while held. The pulse outputs feed the time-setting
//   stage directly, so each pulse is worth exactly one step of adjustment.
//   Keys 2i and 2i+1 form an up/down pair. While both keys of a pair are held,
//   the pair is locked and its pulses are suppressed.
//
// Ports
//   CP       in   clock (10 kHz), rising edge
//   CR       in   asynchronous reset, active low
//   KEY_RAW  in   [N_KEYS]   raw button levels, asynchronous to CP
//   REP_EN   in   auto-repeat enable, synchronous to CP
//   KEY_LVL  out  [N_KEYS]   debounced level, 1 = pressed
//   KEY_P    out  [N_KEYS]   press/repeat pulses, one CP cycle wide
//   LOCK     out  [N_KEYS/2] both keys of the pair are debounced-pressed

// key_lane
//   Per-key path: synchroniser, debouncer, press/repeat FSM.
//   supp is the combinational pair-lock term. It masks the pulse in the same
//   cycle in which the registered LOCK of the pair reads 1.
module key_lane #(
   parameter int DEB_TICKS  = 200,
   parameter int REP_DELAY  = 5000,
   parameter int REP_PERIOD = 2000,
   parameter int KEY_POL    = 1
) (
   input  logic CP,
   input  logic CR,
   input  logic raw,
   input  logic rep_en,
   input  logic supp,
   output logic lvl,
   output logic key_p
);
   localparam int              CW       = $clog2(DEB_TICKS) + 1;
   localparam int              TMAX     = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int              TW       = $clog2(TMAX) + 1;
   localparam logic [CW-1:0]   DEB_LAST = CW'(DEB_TICKS - 1);
   localparam logic [TW-1:0]   DLY_LD   = TW'(REP_DELAY - 1);
   localparam logic [TW-1:0]   PER_LD   = TW'(REP_PERIOD - 1);
   // Raw level of a released key; XOR with it normalises to 1 = pressed.
   localparam logic            RAW_REL  = (KEY_POL == 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HOLD   = 2'd1,
      REPEAT = 2'd2
   } state_t;

   logic          sync1_q, sync2_q, s;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   state_t        st_q, st_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          key_p_q, key_p_d;
   logic          fire;

   // Two-flop synchroniser. It resets to the released level, so a key held
   // through reset looks like a fresh press once it has been debounced.
   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         sync1_q <= RAW_REL;
         sync2_q <= RAW_REL;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q ^ RAW_REL;

   // Debounce. The counter measures consecutive cycles in which s disagrees
   // with the accepted level. Any agreeing cycle clears the count. The
   // DEB_TICKS-th disagreeing cycle flips the level.
   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (s != lvl_q) begin
         if (cnt_q == DEB_LAST) lvl_d = ~lvl_q;
         else                   cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         cnt_q <= '0;
         lvl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end

   // Press/repeat FSM. In IDLE, lvl_q can only be 1 right after a rising
   // edge, because every path into IDLE passes through lvl_q = 0.
   // A release is tested before the timer, so a release wins over a
   // timer reaching zero in the same cycle.
   always_comb begin
      st_d  = st_q;
      tmr_d = tmr_q;
      fire  = 1'b0;
      case (st_q)
         IDLE: begin
            if (lvl_q) begin
               fire  = 1'b1;
               tmr_d = DLY_LD;
               st_d  = HOLD;
            end
         end
         HOLD, REPEAT: begin
            if (!lvl_q) begin
               st_d = IDLE;
            end else if (rep_en) begin
               if (tmr_q == '0) begin
                  fire  = 1'b1;
                  tmr_d = PER_LD;
                  st_d  = REPEAT;
               end else begin
                  tmr_d = tmr_q - TW'(1);
               end
            end
         end
         default: st_d = IDLE;
      endcase
      // The timer keeps running under lock; only the output pulse is masked.
      key_p_d = fire & ~supp;
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) begin
         st_q    <= IDLE;
         tmr_q   <= '0;
         key_p_q <= 1'b0;
      end else begin
         st_q    <= st_d;
         tmr_q   <= tmr_d;
         key_p_q <= key_p_d;
      end
   end

   assign lvl   = lvl_q;
   assign key_p = key_p_q;
endmodule

module key_conditioner #(
   parameter int N_KEYS     = 6,
   parameter int DEB_TICKS  = 200,
   parameter int REP_DELAY  = 5000,
   parameter int REP_PERIOD = 2000,
   parameter int KEY_POL    = 1
) (
   input  logic                CP,
   input  logic                CR,
   input  logic [N_KEYS-1:0]   KEY_RAW,
   input  logic                REP_EN,
   output logic [N_KEYS-1:0]   KEY_LVL,
   output logic [N_KEYS-1:0]   KEY_P,
   output logic [N_KEYS/2-1:0] LOCK
);
   localparam int NP = N_KEYS / 2;

   if (N_KEYS % 2 != 0) begin : g_bad_keys
      $error("key_conditioner: N_KEYS must be even");
   end

   logic [NP-1:0] lock_d, lock_q;

   always_comb begin
      for (int p = 0; p < NP; p++) lock_d[p] = KEY_LVL[2*p] & KEY_LVL[2*p+1];
   end

   always_ff @(posedge CP or negedge CR) begin
      if (!CR) lock_q <= '0;
      else     lock_q <= lock_d;
   end

   assign LOCK = lock_q;

   for (genvar k = 0; k < N_KEYS; k++) begin : g_lane
      key_lane #(
         .DEB_TICKS (DEB_TICKS),
         .REP_DELAY (REP_DELAY),
         .REP_PERIOD(REP_PERIOD),
         .KEY_POL   (KEY_POL)
      ) u_lane (
         .CP    (CP),
         .CR    (CR),
         .raw   (KEY_RAW[k]),
         .rep_en(REP_EN),
         .supp  (lock_d[k/2]),
         .lvl   (KEY_LVL[k]),
         .key_p (KEY_P[k])
      );
   end
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Drives key_conditioner with DEB_TICKS=4, REP_DELAY=10, REP_PERIOD=3 and
//   active-high keys. A behavioural model checks the outputs on every cycle.
//   The model keeps a window of the last DEB synchronised samples and counts
//   enabled cycles since the press. A constant vector table and directed
//   sequences check the latency, bounce, repeat, REP_EN and lockout cases.
module tb_key_conditioner;
   localparam int NK  = 6;
   localparam int DEB = 4;
   localparam int DLY = 10;
   localparam int PER = 3;

   logic          CP = 1'b0;
   logic          CR = 1'b0;
   logic [NK-1:0] KEY_RAW = '0;
   logic          REP_EN = 1'b1;
   logic [NK-1:0] KEY_LVL, KEY_P;
   logic [NK/2-1:0] LOCK;

   key_conditioner #(
      .N_KEYS(NK), .DEB_TICKS(DEB), .REP_DELAY(DLY), .REP_PERIOD(PER), .KEY_POL(1)
   ) dut (
      .CP(CP), .CR(CR), .KEY_RAW(KEY_RAW), .REP_EN(REP_EN),
      .KEY_LVL(KEY_LVL), .KEY_P(KEY_P), .LOCK(LOCK)
   );

   always #5 CP = ~CP;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // ---------------- reference model ----------------
   logic [NK-1:0]   raw_q[$];      // raw samples still in flight to the debouncer
   bit              sh[NK][$];     // last DEB synchronised samples per key
   logic [NK-1:0]   m_lvl, m_p;
   logic [NK/2-1:0] m_lock;
   bit              m_act[NK];
   int              m_en[NK];

   // Bookkeeping of observed DUT events
   int              p_times[NK][$];
   int              rise_cyc[NK];
   int              fall_cyc[NK];
   logic [NK-1:0]   lvl_prev;

   function automatic void model_reset();
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      m_lvl = '0; m_p = '0; m_lock = '0;
      for (int k = 0; k < NK; k++) begin
         sh[k].delete();
         m_act[k] = 0;
         m_en[k]  = 0;
      end
   endfunction

   function automatic void model_edge(input logic [NK-1:0] raw, input logic en);
      logic [NK-1:0] s_now, lvl_pre, fire;
      bit all_diff;
      s_now   = raw_q.pop_front();
      raw_q.push_back(raw);
      lvl_pre = m_lvl;
      fire    = '0;
      for (int k = 0; k < NK; k++) begin
         if (!m_act[k]) begin
            if (lvl_pre[k]) begin
               fire[k] = 1'b1; m_act[k] = 1; m_en[k] = 0;
            end
         end else if (!lvl_pre[k]) begin
            m_act[k] = 0;
         end else if (en) begin
            m_en[k]++;
            if (m_en[k] == DLY || (m_en[k] > DLY && (m_en[k] - DLY) % PER == 0))
               fire[k] = 1'b1;
         end
      end
      for (int i = 0; i < NK/2; i++) m_lock[i] = lvl_pre[2*i] & lvl_pre[2*i+1];
      for (int k = 0; k < NK; k++) m_p[k] = fire[k] & ~m_lock[k/2];
      for (int k = 0; k < NK; k++) begin
         sh[k].push_back(s_now[k]);
         if (sh[k].size() > DEB) void'(sh[k].pop_front());
         all_diff = (sh[k].size() == DEB);
         foreach (sh[k][j]) if (sh[k][j] == lvl_pre[k]) all_diff = 0;
         if (all_diff) m_lvl[k] = ~lvl_pre[k];
      end
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clear_log();
      for (int k = 0; k < NK; k++) begin
         p_times[k].delete();
         rise_cyc[k] = -1;
         fall_cyc[k] = -1;
      end
   endtask

   // Called #1 after a posedge. It drives the inputs, waits for the next
   // edge, advances the model, then compares #1 after that edge.
   task automatic step(input logic [NK-1:0] raw, input logic en);
      KEY_RAW = raw;
      REP_EN  = en;
      @(posedge CP);
      cyc++;
      model_edge(raw, en);
      #1;
      chk("lvl",  int'(KEY_LVL), int'(m_lvl));
      chk("kp",   int'(KEY_P),   int'(m_p));
      chk("lock", int'(LOCK),    int'(m_lock));
      for (int k = 0; k < NK; k++) begin
         if (KEY_P[k]) p_times[k].push_back(cyc);
         if (KEY_LVL[k] && !lvl_prev[k]) rise_cyc[k] = cyc;
         if (!KEY_LVL[k] && lvl_prev[k]) fall_cyc[k] = cyc;
      end
      lvl_prev = KEY_LVL;
   endtask

   task automatic do_reset();
      CR      = 1'b0;
      KEY_RAW = NK'($urandom);
      #1;
      chk("rst_lvl",  int'(KEY_LVL), 0);
      chk("rst_kp",   int'(KEY_P),   0);
      chk("rst_lock", int'(LOCK),    0);
      @(posedge CP);
      #1;
      chk("rst_lvl2", int'(KEY_LVL), 0);
      model_reset();
      lvl_prev = '0;
      CR = 1'b1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b1);
   endtask

   typedef struct {
      logic raw0;
      logic lvl0;
      logic p0;
   } vec_t;
   vec_t tv[20];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      logic [NK-1:0] r;
      int S;
      int durs[6];
      int left[NK];
      bit b;

      // Key 0 held for 8 cycles and then released.
      // KEY_LVL[0] rises 6 cycles after the raw edge; the pulse follows 1 cycle later.
      tv = '{'{1'b1,1'b0,1'b0}, '{1'b1,1'b0,1'b0}, '{1'b1,1'b0,1'b0}, '{1'b1,1'b0,1'b0},
             '{1'b1,1'b0,1'b0}, '{1'b1,1'b1,1'b0}, '{1'b1,1'b1,1'b1}, '{1'b1,1'b1,1'b0},
             '{1'b0,1'b1,1'b0}, '{1'b0,1'b1,1'b0}, '{1'b0,1'b1,1'b0}, '{1'b0,1'b1,1'b0},
             '{1'b0,1'b1,1'b0}, '{1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0},
             '{1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0}, '{1'b0,1'b0,1'b0}};

      clear_log();
      lvl_prev = '0;
      @(posedge CP); #1;

      // 1. Reset with random raw levels, then a few cycles with no pulse
      do_reset();
      r = NK'($urandom);
      for (int i = 0; i < 3; i++) begin
         step(r, 1'b1);
         chk("t1_nopulse", int'(KEY_P), 0);
      end
      settle(12);

      // 2. Clean press on key 0
      clear_log();
      for (int i = 0; i < 20; i++) begin
         step({5'b0, tv[i].raw0}, 1'b1);
         chk("t2_lvl0", int'(KEY_LVL[0]), int'(tv[i].lvl0));
         chk("t2_p0",   int'(KEY_P[0]),   int'(tv[i].p0));
      end
      chk("t2_npulse", p_times[0].size(), 1);
      settle(5);

      // 3. Bounce on key 2: high pulses of 1, 2 and 3 cycles, then a steady high
      clear_log();
      durs = '{1, 2, 2, 2, 3, 2};
      b = 1;
      for (int d = 0; d < 6; d++) begin
         for (int i = 0; i < durs[d]; i++) step(NK'(b) << 2, 1'b0);
         b = ~b;
      end
      S = cyc + 1;
      for (int i = 0; i < 14; i++) step(NK'(1) << 2, 1'b0);
      for (int i = 0; i < 12; i++) step('0, 1'b0);
      chk("t3_rise", rise_cyc[2], S + 5);
      chk("t3_npulse", p_times[2].size(), 1);
      settle(5);

      // 4. Auto-repeat on key 4: pulses at P, P+10, P+13, ... until the release
      clear_log();
      S = cyc + 1;
      for (int i = 0; i < 45; i++) step((i < 30) ? (NK'(1) << 4) : '0, 1'b1);
      chk("t4_npulse", p_times[4].size(), 8);
      for (int j = 0; j < p_times[4].size() && j < 8; j++)
         chk("t4_ptime", p_times[4][j] - S, (j == 0) ? 6 : 16 + PER * (j - 1));
      chk("t4_fall", fall_cyc[4], S + 35);
      settle(5);

      // 5. REP_EN held low for 5 cycles in HOLD delays the first repeat by 5
      clear_log();
      S = cyc + 1;
      for (int i = 0; i < 40; i++)
         step((i < 24) ? (NK'(1) << 5) : '0, !(i >= 10 && i < 15));
      chk("t5_enough", int'(p_times[5].size() >= 2), 1);
      if (p_times[5].size() >= 2) begin
         chk("t5_first", p_times[5][0] - S, 6);
         chk("t5_gap",   p_times[5][1] - p_times[5][0], DLY + 5);
      end
      settle(5);

      // 6. Pair lockout on keys 0 and 1
      clear_log();
      S = cyc + 1;
      for (int i = 0; i < 46; i++) begin
         r = '0;
         r[0] = (i <= 32);
         r[1] = (i >= 2 && i < 20);
         step(r, 1'b1);
         if (i == 10) chk("t6_lock_on",  int'(LOCK[0]), 1);
         if (i == 30) chk("t6_lock_off", int'(LOCK[0]), 0);
      end
      chk("t6_np1", p_times[1].size(), 0);
      chk("t6_np0", p_times[0].size(), 5);
      if (p_times[0].size() >= 2) chk("t6_resume", p_times[0][1] - S, 28);
      settle(5);

      // 7. Random stimulus against the model, with one reset partway through
      for (int k = 0; k < NK; k++) left[k] = 0;
      r = '0;
      b = 1;
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) do_reset();
         for (int k = 0; k < NK; k++) begin
            if (left[k] == 0) begin
               r[k]    = 1'($urandom_range(0, 1));
               left[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40)
                                                     : $urandom_range(1, 6);
            end
            left[k]--;
         end
         if ($urandom_range(0, 19) == 0) b = ~b;
         step(r, b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
